// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, defaults and helpers for the dcache_ctrl slice.
// Optional feature macro used by the slice: DCACHE_PERF_EN (hit/miss counters).
package dcache_pkg;

    // Default geometry: 16 lines of 16 bytes (4 words per line).
    localparam int DCACHE_INDEX_BIT_DEF  = 4;
    localparam int DCACHE_OFFSET_BIT_DEF = 4;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        WB_ADDR = 3'd2,
        WB_WAIT = 3'd3,
        RF_ADDR = 3'd4,
        RF_WAIT = 3'd5,
        RESP    = 3'd6
    } dcache_state_e;

    // Tag field, right-aligned; the caller casts it to its tag width.
    function automatic logic [31:0] addrTag(input logic [31:0] addr,
                                            input int indexBit,
                                            input int offsetBit);
        return addr >> (indexBit + offsetBit);
    endfunction

    // Line index field, right-aligned.
    function automatic logic [31:0] addrIndex(input logic [31:0] addr,
                                              input int offsetBit,
                                              input int indexBit);
        return (addr >> offsetBit) & ((32'd1 << indexBit) - 32'd1);
    endfunction

    // Word number within the line (byte offset with the low two bits dropped).
    function automatic logic [31:0] addrWord(input logic [31:0] addr,
                                             input int offsetBit);
        return (addr & ((32'd1 << offsetBit) - 32'd1)) >> 2;
    endfunction

    // Replace only the bytes of oldWord whose strobe bit is set.
    function automatic logic [31:0] byteMerge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  strb);
        logic [31:0] merged;
        merged = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = newWord[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: per-line valid/dirty/tag state and line data for dcache_ctrl.
// Reads are combinational by index; writes are one word (byte-masked) plus metadata per cycle.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BIT  = DCACHE_INDEX_BIT_DEF,
    parameter int OFFSET_BIT = DCACHE_OFFSET_BIT_DEF,
    parameter int TAG_BIT    = 32 - INDEX_BIT - OFFSET_BIT,
    parameter int BEAT_W     = OFFSET_BIT - 2,
    parameter int WORDS      = 1 << BEAT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BIT-1:0]   index_i,
    output logic                   rdValid_o,
    output logic                   rdDirty_o,
    output logic [TAG_BIT-1:0]     rdTag_o,
    output logic [WORDS-1:0][31:0] rdLine_o,
    input  logic                   dataWe_i,
    input  logic [BEAT_W-1:0]      dataWord_i,
    input  logic [3:0]             dataStrb_i,
    input  logic [31:0]            dataWdata_i,
    input  logic                   metaWe_i,
    input  logic                   metaValid_i,
    input  logic                   metaDirty_i,
    input  logic [TAG_BIT-1:0]     metaTag_i
);

    localparam int LINES = 1 << INDEX_BIT;

    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_BIT-1:0]     tagMem  [LINES];
    logic [WORDS-1:0][31:0] dataMem [LINES];

    // Valid and dirty clear asynchronously so a reset drops every line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (metaWe_i) begin
            valid_q[index_i] <= metaValid_i;
            dirty_q[index_i] <= metaDirty_i;
        end
    end

    // Tag and data carry no reset; they only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        if (metaWe_i) tagMem[index_i] <= metaTag_i;
        if (dataWe_i) begin
            dataMem[index_i][dataWord_i] <= byteMerge(dataMem[index_i][dataWord_i],
                                                      dataWdata_i, dataStrb_i);
        end
    end

    assign rdValid_o = valid_q[index_i];
    assign rdDirty_o = dirty_q[index_i];
    assign rdTag_o   = tagMem[index_i];
    assign rdLine_o  = dataMem[index_i];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate, direct-mapped data-cache controller.
// Sequences lookup, dirty-victim write-back and refill between the CPU and the memory bridge.
// Define DCACHE_PERF_EN to build the hit/miss performance counters; otherwise they read 0.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BIT  = DCACHE_INDEX_BIT_DEF,
    parameter int OFFSET_BIT = DCACHE_OFFSET_BIT_DEF,
    parameter int TAG_BIT    = 32 - INDEX_BIT - OFFSET_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
);

    localparam int BEAT_W = OFFSET_BIT - 2;
    localparam int WORDS  = 1 << BEAT_W;

    dcache_state_e          state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [31:0]            reqAddr_q;
    logic [31:0]            reqWdata_q;
    logic [3:0]             reqStrb_q;
    logic                   reqWr_q;

    logic [INDEX_BIT-1:0]   reqIndex;
    logic [TAG_BIT-1:0]     reqTag;
    logic [BEAT_W-1:0]      reqWord;

    logic                   rdValid, rdDirty;
    logic [TAG_BIT-1:0]     rdTag;
    logic [WORDS-1:0][31:0] rdLine;

    logic                   dataWe, metaWe, metaValid, metaDirty;
    logic [BEAT_W-1:0]      dataWord;
    logic [3:0]             dataStrb;
    logic [31:0]            dataWdata;
    logic [TAG_BIT-1:0]     metaTag;

    logic                   hit, lastBeat, inWriteBack, beatDone, respond;

    assign reqIndex    = INDEX_BIT'(addrIndex(reqAddr_q, OFFSET_BIT, INDEX_BIT));
    assign reqTag      = TAG_BIT'(addrTag(reqAddr_q, INDEX_BIT, OFFSET_BIT));
    assign reqWord     = BEAT_W'(addrWord(reqAddr_q, OFFSET_BIT));
    assign hit         = rdValid && (rdTag == reqTag);
    assign lastBeat    = &beat_q;
    assign inWriteBack = (state_q == WB_ADDR) || (state_q == WB_WAIT);

    dcache_line_store #(
        .INDEX_BIT  (INDEX_BIT),
        .OFFSET_BIT (OFFSET_BIT),
        .TAG_BIT    (TAG_BIT)
    ) u_line_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .index_i     (reqIndex),
        .rdValid_o   (rdValid),
        .rdDirty_o   (rdDirty),
        .rdTag_o     (rdTag),
        .rdLine_o    (rdLine),
        .dataWe_i    (dataWe),
        .dataWord_i  (dataWord),
        .dataStrb_i  (dataStrb),
        .dataWdata_i (dataWdata),
        .metaWe_i    (metaWe),
        .metaValid_i (metaValid),
        .metaDirty_i (metaDirty),
        .metaTag_i   (metaTag)
    );

    // Next-state, handshake outputs and line-store writes; a beat completes on
    // mem_data_ok, which may coincide with mem_addr_ok and then skips the WAIT state.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dataWe      = 1'b0;
        dataWord    = reqWord;
        dataStrb    = reqStrb_q;
        dataWdata   = reqWdata_q;
        metaWe      = 1'b0;
        metaValid   = 1'b1;
        metaDirty   = 1'b1;
        metaTag     = reqTag;
        beatDone    = 1'b0;
        respond     = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_addr_ok = cpu_req & rst_n;
                if (cpu_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    respond = 1'b1;
                end else begin
                    beat_d  = '0;
                    state_d = (rdValid && rdDirty) ? WB_ADDR : RF_ADDR;
                end
            end
            WB_ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {rdTag, reqIndex, beat_q, 2'b00};
                mem_wdata = rdLine[beat_q];
                if (mem_addr_ok) begin
                    if (mem_data_ok) beatDone = 1'b1;
                    else             state_d  = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (mem_data_ok) beatDone = 1'b1;
            end
            RF_ADDR: begin
                mem_req  = 1'b1;
                mem_addr = {reqTag, reqIndex, beat_q, 2'b00};
                if (mem_addr_ok) begin
                    if (mem_data_ok) beatDone = 1'b1;
                    else             state_d  = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (mem_data_ok) beatDone = 1'b1;
            end
            RESP: begin
                respond = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (beatDone) begin
            beat_d = beat_q + 1'b1;
            if (inWriteBack) begin
                state_d = lastBeat ? RF_ADDR : WB_ADDR;
            end else begin
                dataWe    = 1'b1;
                dataWord  = beat_q;
                dataStrb  = 4'hF;
                dataWdata = mem_rdata;
                if (lastBeat) begin
                    metaWe    = 1'b1;
                    metaDirty = 1'b0;
                    state_d   = RESP;
                end else begin
                    state_d   = RF_ADDR;
                end
            end
        end

        if (respond) begin
            cpu_data_ok = 1'b1;
            state_d     = IDLE;
            if (reqWr_q) begin
                dataWe = 1'b1;
                metaWe = 1'b1;
            end else begin
                cpu_rdata = rdLine[reqWord];
            end
        end
    end

    // FSM state, beat counter and the request captured when it is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
            reqStrb_q  <= '0;
            reqWr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (state_q == IDLE && cpu_req) begin
                reqAddr_q  <= cpu_addr;
                reqWdata_q <= cpu_wdata;
                reqStrb_q  <= cpu_wstrb;
                reqWr_q    <= cpu_wr;
            end
        end
    end

`ifdef DCACHE_PERF_EN
    logic        lookupHit, lookupMiss;
    logic [31:0] hitCnt_q, missCnt_q;

    assign lookupHit  = (state_q == LOOKUP) && hit;
    assign lookupMiss = (state_q == LOOKUP) && !hit;

    // Free-running hit/miss counters, one step per LOOKUP outcome, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else begin
            if (lookupHit)  hitCnt_q  <= hitCnt_q + 32'd1;
            if (lookupMiss) missCnt_q <= missCnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt  = hitCnt_q;
    assign perf_miss_cnt = missCnt_q;
`else
    assign perf_hit_cnt  = '0;
    assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl at the default geometry
// (16 lines x 4 words). A reference cache model predicts memory traffic and load data.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_wr;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [31:0] perf_hit_cnt, perf_miss_cnt;

    dcache_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req       (cpu_req),
        .cpu_wr        (cpu_wr),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_addr_ok   (cpu_addr_ok),
        .cpu_data_ok   (cpu_data_ok),
        .cpu_rdata     (cpu_rdata),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_addr_ok   (mem_addr_ok),
        .mem_data_ok   (mem_data_ok),
        .mem_rdata     (mem_rdata),
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } memTxn_t;

    int          checkCount  = 0;
    int          errorCount  = 0;
    memTxn_t     expMemQ[$];
    logic [31:0] expRdQ[$];

    logic [31:0] memArr [256];
    logic        mValid [16];
    logic        mDirty [16];
    logic [23:0] mTag   [16];
    logic [31:0] mData  [16][4];
    int          modelHits   = 0;
    int          modelMisses = 0;

    int          stallCycles = 0;
    int          dataDelay   = 1;
    bit          sameCycle   = 0;

    // Count one comparison and report it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference cache: predicts hit/miss, pushes expected memory beats and load data.
    task automatic modelAccess(input logic wr, input logic [31:0] addr,
                               input logic [3:0] strb, input logic [31:0] wdata,
                               output bit isHit);
        logic [3:0]  idx;
        logic [23:0] tg;
        logic [1:0]  w;
        logic [31:0] a;
        memTxn_t     t;
        idx = addr[7:4];
        tg  = addr[31:8];
        w   = addr[3:2];
        isHit = mValid[idx] && (mTag[idx] == tg);
        if (isHit) begin
            modelHits++;
        end else begin
            modelMisses++;
            if (mValid[idx] && mDirty[idx]) begin
                for (int b = 0; b < 4; b++) begin
                    a = {mTag[idx], idx, 2'(b), 2'b00};
                    t.wr = 1'b1; t.addr = a; t.data = mData[idx][b];
                    expMemQ.push_back(t);
                end
            end
            for (int b = 0; b < 4; b++) begin
                a = {tg, idx, 2'(b), 2'b00};
                t.wr = 1'b0; t.addr = a; t.data = memArr[a[9:2]];
                expMemQ.push_back(t);
                mData[idx][b] = memArr[a[9:2]];
            end
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
            mTag[idx]   = tg;
        end
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) mData[idx][w][8*k +: 8] = wdata[8*k +: 8];
            end
            mDirty[idx] = 1'b1;
        end else begin
            expRdQ.push_back(mData[idx][w]);
        end
    endtask

    // Issue one CPU access, wait (bounded) for its response and score it.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [3:0] strb, input logic [31:0] wdata);
        bit          isHit;
        int          waitCnt;
        logic [31:0] expData;
        modelAccess(wr, addr, strb, wdata, isHit);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = wdata;
        #1;
        waitCnt = 0;
        while (!cpu_addr_ok && waitCnt < 50) begin
            @(negedge clk); #1; waitCnt++;
        end
        checkOutput("cpu_addr_ok", 32'(cpu_addr_ok), 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        waitCnt = 1;
        while (!cpu_data_ok && waitCnt < 500) begin
            @(negedge clk); #1; waitCnt++;
        end
        checkOutput("cpu_data_ok", 32'(cpu_data_ok), 32'd1);
        if (isHit) checkOutput("hit_latency", waitCnt, 32'd1);
        if (!wr) begin
            expData = expRdQ.pop_front();
            checkOutput("load_data", cpu_rdata, expData);
        end
        checkOutput("mem_beats_left", expMemQ.size(), 32'd0);
        @(negedge clk); #1;
        checkOutput("rdata_idle", cpu_rdata, 32'd0);
    endtask

    // Memory bridge model: optional address stall, data one or more cycles later
    // or in the same cycle; every accepted beat is scored against the model queue.
    logic [31:0] heldAddr, heldWdata, pendRdata;
    bit          pending;
    int          stallCnt, dataWait;
    memTxn_t     curTxn;
    initial begin
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        pending = 0; stallCnt = 0; dataWait = 0;
        heldAddr = '0; heldWdata = '0; pendRdata = '0;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
            if (!rst_n) begin
                pending = 0; stallCnt = 0;
            end else if (pending) begin
                if (dataWait > 1) begin
                    dataWait--;
                end else begin
                    mem_data_ok = 1'b1; mem_rdata = pendRdata; pending = 0;
                end
            end else if (mem_req) begin
                if (stallCnt == 0) begin
                    heldAddr = mem_addr; heldWdata = mem_wdata;
                end
                if (stallCnt < stallCycles) begin
                    stallCnt++;
                end else begin
                    if (stallCycles > 0) begin
                        checkOutput("hold_addr", mem_addr, heldAddr);
                        checkOutput("hold_wdata", mem_wdata, heldWdata);
                    end
                    stallCnt = 0;
                    mem_addr_ok = 1'b1;
                    if (expMemQ.size() == 0) begin
                        checkOutput("mem_extra_beat", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        curTxn = expMemQ.pop_front();
                        checkOutput("mem_wr", 32'(mem_wr), 32'(curTxn.wr));
                        checkOutput("mem_addr", mem_addr, curTxn.addr);
                        if (curTxn.wr) checkOutput("mem_wdata", mem_wdata, curTxn.data);
                    end
                    if (mem_wr) begin
                        memArr[mem_addr[9:2]] = mem_wdata;
                        pendRdata = '0;
                    end else begin
                        pendRdata = memArr[mem_addr[9:2]];
                    end
                    if (sameCycle) begin
                        mem_data_ok = 1'b1; mem_rdata = pendRdata;
                    end else begin
                        pending = 1; dataWait = dataDelay;
                    end
                end
            end
        end
    end

    // Main sequence.
    initial begin
        bit isHit;
        int waitCnt;
        logic [31:0] expHit, expMiss;

        for (int i = 0; i < 256; i++) memArr[i] = 32'hC000_0000 | (i << 2);
        memArr[5] = 32'h1122_3344;
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0; mDirty[i] = 1'b0; mTag[i] = '0;
        end

        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_wstrb = 4'h0;
        cpu_addr = 32'h10; cpu_wdata = '0;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        checkOutput("rst_cpu_addr_ok", 32'(cpu_addr_ok), 32'd0);
        checkOutput("rst_cpu_data_ok", 32'(cpu_data_ok), 32'd0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_perf_hit", perf_hit_cnt, 32'd0);
        checkOutput("rst_perf_miss", perf_miss_cnt, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Cold miss, then hit on the same word.
        applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);

        // Partial store merged into 0x11223344, read back.
        applyStimulus(1'b1, 32'h14, 4'b0011, 32'hAABB_CCDD);
        applyStimulus(1'b0, 32'h14, 4'h0, 32'h0);
        checkOutput("merge_value", cpu_rdata, 32'h0);

        // Dirty conflict: write-back of 0x10 line, then refill of 0x110 line.
        applyStimulus(1'b0, 32'h110, 4'h0, 32'h0);
        checkOutput("wb_mem_0x14", memArr[5], 32'h1122_CCDD);

        // Long address stalls and slow data.
        applyStimulus(1'b1, 32'h118, 4'b1100, 32'h5566_7788);
        stallCycles = 5; dataDelay = 3;
        applyStimulus(1'b0, 32'h10, 4'h0, 32'h0);
        stallCycles = 0; dataDelay = 1;

        // Data in the same cycle as address acceptance.
        sameCycle = 1;
        applyStimulus(1'b1, 32'h18, 4'b1111, 32'h0BAD_F00D);
        applyStimulus(1'b0, 32'h114, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h118, 4'h0, 32'h0);
        sameCycle = 0;

        // Reset during the second refill beat of a fresh miss.
        modelAccess(1'b0, 32'h20, 4'h0, 32'h0, isHit);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h20; cpu_wstrb = 4'h0;
        #1;
        waitCnt = 0;
        while (!cpu_addr_ok && waitCnt < 50) begin
            @(negedge clk); #1; waitCnt++;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        waitCnt = 0;
        while (!(mem_req && !mem_wr && mem_addr == 32'h24) && waitCnt < 100) begin
            @(negedge clk); #1; waitCnt++;
        end
        checkOutput("beat2_seen", mem_addr, 32'h24);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("midrst_cpu_data_ok", 32'(cpu_data_ok), 32'd0);
        checkOutput("midrst_perf_miss", perf_miss_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expMemQ.delete();
        expRdQ.delete();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0; mDirty[i] = 1'b0;
        end
        modelHits = 0; modelMisses = 0;

        // After reset: original address misses again, then 3 hits and one more miss.
        applyStimulus(1'b0, 32'h20, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h20, 4'h0, 32'h0);
        applyStimulus(1'b0, 32'h24, 4'h0, 32'h0);
        applyStimulus(1'b1, 32'h28, 4'b0101, 32'h1234_5678);
        applyStimulus(1'b0, 32'h110, 4'h0, 32'h0);
`ifdef DCACHE_PERF_EN
        expHit  = 32'(modelHits);
        expMiss = 32'(modelMisses);
`else
        expHit  = 32'd0;
        expMiss = 32'd0;
`endif
        checkOutput("perf_hit_cnt", perf_hit_cnt, expHit);
        checkOutput("perf_miss_cnt", perf_miss_cnt, expMiss);

        // Mixed random traffic with varying memory timing.
        for (int n = 0; n < 24; n++) begin
            stallCycles = $urandom_range(0, 3);
            dataDelay   = $urandom_range(1, 3);
            sameCycle   = ($urandom_range(0, 3) == 0);
            applyStimulus(1'($urandom_range(0, 1)),
                          {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                          4'($urandom_range(1, 15)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Global time limit so a stuck handshake still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
